// File: rtl/dmem_latency_ram.sv
// Word-addressed data memory with a valid/ready request port, programmable
// wait states before accept, and a fixed-depth in-order response pipe.
module dmem_latency_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1,
  parameter int WAIT_CYCLES  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_op,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_mask,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic                    resp_write,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    busy
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; the requester holds op/addr/mask/wdata stable
  // from raising req_valid until that edge, and may drop req_valid early
  // to abandon the request. Responses have no back-pressure.

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic accept;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_write;
  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (WAIT_CYCLES == 0) begin
          req_ready = 1'b1;
        end else if (req_valid) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        req_ready = (cnt == 3'd0);
        if (!req_valid || cnt == 3'd0) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Nothing is accepted while reset is held, so no write can slip in.
  assign accept = req_valid & req_ready & rst;

  always_ff @(posedge clk) begin
    if (accept && req_op) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (req_mask[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      pipe_write <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_write[0] <= accept & req_op;
      pipe_data[0]  <= (accept && !req_op) ? mem[req_addr] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_write[i] <= pipe_write[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign resp_valid = pipe_valid[READ_LATENCY-1];
  assign resp_write = pipe_write[READ_LATENCY-1];
  assign resp_rdata = pipe_data[READ_LATENCY-1];
  assign busy       = (state == ST_WAIT) | (|pipe_valid);

endmodule

// File: tb/tb_dmem_latency_ram.sv
// Bench for dmem_latency_ram: three configurations driven side by side, each
// checked by a response scoreboard fed from a word-array reference model.
module tb_dmem_latency_ram;

  typedef struct packed {
    logic        chk;
    logic        wr;
    logic [31:0] data;
    int          at_cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_op     [3];
  logic [13:0] req_addr   [3];
  logic [3:0]  req_mask   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_write [3];
  logic [31:0] resp_rdata [3];
  logic        busy       [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  resp_t       exp_q [3][$];
  logic [31:0] ref_mem [3][16384];
  bit          known   [3][16384];
  resp_t       mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_latency_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .READ_LATENCY(1), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_addr(req_addr[0]), .req_mask(req_mask[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_write(resp_write[0]), .resp_rdata(resp_rdata[0]), .busy(busy[0]));

  dmem_latency_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .READ_LATENCY(3), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_addr(req_addr[1]), .req_mask(req_mask[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_write(resp_write[1]), .resp_rdata(resp_rdata[1]), .busy(busy[1]));

  dmem_latency_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .READ_LATENCY(2), .WAIT_CYCLES(3)) u2 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_op(req_op[2]), .req_addr(req_addr[2]), .req_mask(req_mask[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_write(resp_write[2]), .resp_rdata(resp_rdata[2]), .busy(busy[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction

  function automatic int wait_of(input int k);
    return (k == 2) ? 3 : 0;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: called at the negedge before the accepting edge.
  task automatic model_accept(input int k, input logic op, input logic [13:0] addr,
                              input logic [3:0] mask, input logic [31:0] wdata);
    resp_t e;
    e.at_cyc = cyc + lat_of(k);
    if (op) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) ref_mem[k][addr][8*b +: 8] = wdata[8*b +: 8];
      if (mask == 4'hf) known[k][addr] = 1'b1;
      e.chk = 1'b1; e.wr = 1'b1; e.data = 32'h0;
    end else begin
      e.chk = known[k][addr]; e.wr = 1'b0; e.data = ref_mem[k][addr];
    end
    exp_q[k].push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds one request until accepted; the stall count must match the wait setting.
  task automatic issue(input int k, input logic op, input logic [13:0] addr,
                       input logic [3:0] mask, input logic [31:0] wdata);
    int  waits;
    bit  done;
    waits = 0;
    done  = 1'b0;
    req_op[k] = op; req_addr[k] = addr; req_mask[k] = mask; req_wdata[k] = wdata;
    req_valid[k] = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        done = 1'b1;
        model_accept(k, op, addr, mask, wdata);
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    req_valid[k] = 1'b0;
    checks++;
    if (!done || waits != wait_of(k)) begin
      errors++;
      $display("FAIL accept_stall[%0d]: got accepted=%0b after %0d stalls, required accept after %0d stalls",
               k, done, waits, wait_of(k));
    end
  endtask

  task automatic rand_run(input int k);
    for (int a = 0; a < 16; a++) issue(k, 1'b1, 14'(a), 4'hf, $urandom);
    for (int i = 0; i < 40; i++) begin
      issue(k, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom);
      idle($urandom_range(0, 2));
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (resp_valid[k] === 1'b1) begin
        checks++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected[%0d]: got write=%b rdata=%h at cycle %0d, required no response",
                   k, resp_write[k], resp_rdata[k], cyc);
        end else begin
          mon_e = exp_q[k].pop_front();
          if (resp_write[k] !== mon_e.wr || cyc != mon_e.at_cyc ||
              (mon_e.chk && resp_rdata[k] !== mon_e.data)) begin
            errors++;
            $display("FAIL resp[%0d]: got write=%b rdata=%h cycle=%0d, required write=%b rdata=%h cycle=%0d",
                     k, resp_write[k], resp_rdata[k], cyc, mon_e.wr, mon_e.data, mon_e.at_cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; req_valid[k] = 1'b0; req_op[k] = 1'b0;
      req_addr[k] = '0; req_mask[k] = '0; req_wdata[k] = '0;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      check_bit("reset_req_ready", req_ready[k], wait_of(k) == 0);
      check_bit("reset_resp_valid", resp_valid[k], 1'b0);
      check_bit("reset_resp_write", resp_write[k], 1'b0);
      check_word("reset_resp_rdata", resp_rdata[k], 32'h0);
      check_bit("reset_busy", busy[k], 1'b0);
    end
    idle(2);
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    idle(1);

    // Single-cycle latency read of a word written through the port.
    issue(0, 1'b1, 14'h400, 4'hf, 32'hdeadbeef);
    issue(0, 1'b0, 14'h400, 4'h0, 32'h0);

    // Byte-masked writes, including an empty mask.
    issue(0, 1'b1, 14'h010, 4'hf, 32'h0);
    issue(0, 1'b1, 14'h010, 4'b0001, 32'h12345678);
    issue(0, 1'b0, 14'h010, 4'h0, 32'h0);
    issue(0, 1'b1, 14'h010, 4'b1100, 32'h12345678);
    issue(0, 1'b0, 14'h010, 4'h0, 32'h0);
    issue(0, 1'b1, 14'h010, 4'b0000, 32'hffffffff);
    issue(0, 1'b0, 14'h010, 4'h0, 32'h0);
    idle(3);

    // Back-to-back accepts through a three-deep pipe.
    issue(1, 1'b1, 14'h021, 4'hf, 32'h5a5a5a5a);
    idle(4);
    issue(1, 1'b1, 14'h020, 4'hf, 32'hcafef00d);
    issue(1, 1'b0, 14'h020, 4'h0, 32'h0);
    issue(1, 1'b0, 14'h021, 4'h0, 32'h0);
    idle(5);

    // Wait states: ready only in the fourth cycle, busy until the response.
    issue(2, 1'b1, 14'h040, 4'hf, 32'ha5a50f0f);
    idle(4);
    req_op[2] = 1'b0; req_addr[2] = 14'h040; req_mask[2] = 4'h0; req_valid[2] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_bit("wait_ready", req_ready[2], i == 4);
      if (i >= 2) check_bit("wait_busy", busy[2], 1'b1);
      if (i == 4) model_accept(2, 1'b0, 14'h040, 4'h0, 32'h0);
      @(posedge clk);
      #1;
    end
    req_valid[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_bit("pipe_busy", busy[2], 1'b1);
    end
    @(negedge clk);
    check_bit("drained_busy", busy[2], 1'b0);
    @(posedge clk);
    #1;

    // Abandoned write during wait: nothing accepted, FSM back to idle.
    req_op[2] = 1'b1; req_addr[2] = 14'h040; req_mask[2] = 4'hf;
    req_wdata[2] = 32'hffffffff; req_valid[2] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_bit("abandon_ready", req_ready[2], 1'b0);
      @(posedge clk);
      #1;
    end
    req_valid[2] = 1'b0;
    idle(1);
    @(negedge clk);
    check_bit("abandon_busy", busy[2], 1'b0);
    @(posedge clk);
    #1;
    issue(2, 1'b0, 14'h040, 4'h0, 32'h0);
    idle(4);

    // Reset right after a read accept drops the response but keeps memory.
    issue(2, 1'b0, 14'h040, 4'h0, 32'h0);
    rst[2] = 1'b0;
    exp_q[2].delete();
    repeat (3) begin
      @(negedge clk);
      check_bit("rst_resp_valid", resp_valid[2], 1'b0);
      check_bit("rst_resp_write", resp_write[2], 1'b0);
      check_word("rst_resp_rdata", resp_rdata[2], 32'h0);
      check_bit("rst_busy", busy[2], 1'b0);
    end
    @(posedge clk);
    #1;
    rst[2] = 1'b1;
    req_op[2] = 1'b1; req_addr[2] = 14'h040; req_mask[2] = 4'hf;
    req_wdata[2] = 32'h0badf00d; req_valid[2] = 1'b1;
    idle(1);
    rst[2] = 1'b0;
    req_valid[2] = 1'b0;
    idle(1);
    rst[2] = 1'b1;
    idle(1);
    issue(2, 1'b0, 14'h040, 4'h0, 32'h0);
    idle(4);

    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
    join
    idle(10);

    for (int k = 0; k < 3; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL resp_missing[%0d]: got %0d responses outstanding, required 0", k, exp_q[k].size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
